// File: rtl/slave_port.sv
// Serial-to-parallel slave-side bus port.
// Deserialises address/mode/write data from the bus, issues single-cycle memory
// write/read strobes, and serialises read data back onto srdata/svalid.
// Optional feature: define SLAVE_PORT_WRITE_ACK_EN to add a one-cycle write
// acknowledge (svalid=1, srdata=1) right after the memory write strobe.
module slave_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sbusy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned MaxWidth = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntWidth = $clog2(MaxWidth) + 1;
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
  localparam logic [CntWidth-1:0] AddrLast = CntWidth'(ADDR_WIDTH - 1);
  localparam logic [CntWidth-1:0] DataLast = CntWidth'(DATA_WIDTH - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StAddr  = 3'd1;
  localparam logic [2:0] StWdata = 3'd2;
  localparam logic [2:0] StMemwr = 3'd3;
  localparam logic [2:0] StMemrd = 3'd4;
  localparam logic [2:0] StRwait = 3'd5;
  localparam logic [2:0] StRdata = 3'd6;
  localparam logic [2:0] StAck   = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  srdata_q, srdata_d;
  logic                  svalid_q, svalid_d;
  logic                  sbusy_q, sbusy_d;
  logic                  mem_wen_q, mem_wen_d;
  logic                  mem_ren_q, mem_ren_d;

  // Next-state logic: frame deserialisation, memory access sequencing, read serialisation.
  // Shift registers fill LSB first; mem_addr/mem_wdata only update when a frame
  // completes, so an aborted frame never disturbs the last latched values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      StIdle: begin
        if (mvalid) begin
          mode_d    = smode;
          addr_sh_d = {swdata, addr_sh_q[ADDR_WIDTH-1:1]};
          cnt_d     = CntOne;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (!mvalid) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          addr_sh_d = {swdata, addr_sh_q[ADDR_WIDTH-1:1]};
          if (cnt_q == AddrLast) begin
            cnt_d = '0;
            if (mode_q) begin
              state_d = StWdata;
            end else begin
              mem_addr_d = addr_sh_d;
              state_d    = StMemrd;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      StWdata: begin
        if (!mvalid) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          data_sh_d = {swdata, data_sh_q[DATA_WIDTH-1:1]};
          if (cnt_q == DataLast) begin
            cnt_d       = '0;
            mem_addr_d  = addr_sh_q;
            mem_wdata_d = data_sh_d;
            state_d     = StMemwr;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
`ifdef SLAVE_PORT_WRITE_ACK_EN
      StMemwr: state_d = StAck;
      StAck:   state_d = StIdle;
`else
      StMemwr: state_d = StIdle;
`endif
      StMemrd: state_d = StRwait;
      StRwait: begin
        data_sh_d = mem_rdata;
        cnt_d     = '0;
        state_d   = StRdata;
      end
      StRdata: begin
        data_sh_d = data_sh_q >> 1;
        if (cnt_q == DataLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    svalid_d  = (state_d == StRdata) || (state_d == StAck);
    srdata_d  = (state_d == StRdata) ? data_sh_d[0] : (state_d == StAck);
    sbusy_d   = (state_d != StIdle);
    mem_wen_d = (state_d == StMemwr);
    mem_ren_d = (state_d == StMemrd);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      srdata_q    <= 1'b0;
      svalid_q    <= 1'b0;
      sbusy_q     <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      srdata_q    <= srdata_d;
      svalid_q    <= svalid_d;
      sbusy_q     <= sbusy_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
    end
  end

  assign srdata    = srdata_q;
  assign svalid    = svalid_q;
  assign sbusy     = sbusy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign mem_ren   = mem_ren_q;

endmodule

// File: tb/tb_slave_port.sv
// Self-checking bench for slave_port: a frame-level model fills per-cycle
// expectations, a negedge process compares every cycle, and literal checks pin
// the headline timing points.
`timescale 1ns/1ps
module tb_slave_port;
  localparam int A = 12;
  localparam int D = 8;
  localparam int N = 1024;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         swdata = 1'b0;
  logic         smode = 1'b0;
  logic         mvalid = 1'b0;
  logic         srdata, svalid, sbusy, mem_wen, mem_ren;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_wdata;
  logic [D-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  slave_port #(.ADDR_WIDTH(A), .DATA_WIDTH(D)) dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sbusy(sbusy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data valid for exactly the cycle after mem_ren, garbage otherwise.
  bit [D-1:0] mem     [1 << A];
  bit [D-1:0] exp_mem [1 << A];
  bit         rd_hold = 1'b0;
  always @(negedge clk) begin
    if (mem_wen) mem[mem_addr] = mem_wdata;
    if (mem_ren) begin
      mem_rdata = mem[mem_addr];
      rd_hold   = 1'b1;
    end else if (rd_hold) begin
      rd_hold = 1'b0;
    end else begin
      mem_rdata = D'($urandom);
    end
  end

  // Per-cycle expectations and recorded DUT values.
  bit         e_busy [N], e_wen [N], e_ren [N], e_sv [N], e_sd [N];
  bit [A-1:0] e_addr [N];
  bit [D-1:0] e_wdata [N];
  bit         a_busy [N], a_wen [N], a_ren [N], a_sv [N], a_sd [N];
  bit [A-1:0] a_addr [N];
  bit [D-1:0] a_wdata [N];

  int         n_tests = 0;
  int         n_fail = 0;
  bit [A-1:0] hold_addr = '0;
  bit [D-1:0] hold_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the frame model.
  always @(negedge clk) begin
    if (cyc < N) begin
      a_busy[cyc] = sbusy;  a_wen[cyc] = mem_wen; a_ren[cyc] = mem_ren;
      a_sv[cyc] = svalid;   a_sd[cyc] = srdata;
      a_addr[cyc] = mem_addr; a_wdata[cyc] = mem_wdata;
      if (e_wen[cyc]) begin
        hold_addr  = e_addr[cyc];
        hold_wdata = e_wdata[cyc];
      end
      if (e_ren[cyc]) hold_addr = e_addr[cyc];
      chk("sbusy", 32'(sbusy), 32'(e_busy[cyc]));
      chk("mem_wen", 32'(mem_wen), 32'(e_wen[cyc]));
      chk("mem_ren", 32'(mem_ren), 32'(e_ren[cyc]));
      chk("svalid", 32'(svalid), 32'(e_sv[cyc]));
      chk("mem_addr", 32'(mem_addr), 32'(hold_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(hold_wdata));
      if (e_sv[cyc]) chk("srdata", 32'(srdata), 32'(e_sd[cyc]));
    end
  end

  // Runs one frame starting at the current cycle (called #1 after a posedge) and
  // records what the port must do. abort_at>0 drops mvalid after that many bits;
  // reset_at>=0 pulses rstn in that post-frame cycle.
  task automatic run_frame(input bit wr, input bit [A-1:0] a, input bit [D-1:0] d,
                           input int abort_at, input bit stray, input int reset_at,
                           output int t0);
    bit [A+D-1:0] bits;
    bit [D-1:0]   rd;
    int           nb;
    int           post;
    t0   = cyc;
    bits = {d, a};
    nb   = wr ? A + D : A;
    if (abort_at > 0) begin
      nb = abort_at;
      for (int k = 1; k <= abort_at; k++) e_busy[t0+k] = 1'b1;
    end else if (wr) begin
      for (int k = 1; k <= A + D; k++) e_busy[t0+k] = 1'b1;
      e_wen[t0+A+D] = 1'b1; e_addr[t0+A+D] = a; e_wdata[t0+A+D] = d;
      exp_mem[a] = d;
`ifdef SLAVE_PORT_WRITE_ACK_EN
      e_busy[t0+A+D+1] = 1'b1; e_sv[t0+A+D+1] = 1'b1; e_sd[t0+A+D+1] = 1'b1;
`endif
    end else begin
      rd = exp_mem[a];
      for (int k = 1; k <= A + D + 1; k++) e_busy[t0+k] = 1'b1;
      e_ren[t0+A] = 1'b1; e_addr[t0+A] = a;
      for (int i = 0; i < D; i++) begin
        e_sv[t0+A+2+i] = 1'b1;
        e_sd[t0+A+2+i] = rd[i];
      end
    end
    for (int i = 0; i < nb; i++) begin
      mvalid = 1'b1;
      smode  = (i == 0) ? wr : ~wr;
      swdata = bits[i];
      @(posedge clk); #1;
    end
    mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
    if (abort_at > 0) begin
      @(posedge clk); #1;
    end else begin
`ifdef SLAVE_PORT_WRITE_ACK_EN
      post = wr ? 2 : D + 2;
`else
      post = wr ? 1 : D + 2;
`endif
      for (int j = 0; j < post; j++) begin
        if (stray) begin
          mvalid = 1'($urandom); swdata = 1'($urandom); smode = 1'($urandom);
        end
        if (j == reset_at) begin
          #1;
          rstn = 1'b0;
          for (int c = cyc; c < N; c++) begin
            e_busy[c] = 1'b0; e_wen[c] = 1'b0; e_ren[c] = 1'b0;
            e_sv[c] = 1'b0;   e_sd[c] = 1'b0;
          end
          hold_addr = '0; hold_wdata = '0;
          #1;
          chk("rst_async_svalid", 32'(svalid), 32'd0);
          chk("rst_async_srdata", 32'(srdata), 32'd0);
          chk("rst_async_sbusy", 32'(sbusy), 32'd0);
        end
        @(posedge clk); #1;
        if (j == reset_at) rstn = 1'b1;
      end
      mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
    end
  endtask

  initial begin
    int      t0, t1;
    bit [D-1:0] b;
    int      cnt;
    for (int i = 0; i < (1 << A); i++) begin
      mem[i] = '0; exp_mem[i] = '0;
    end
    mem[12'h3A5] = 8'h5A; exp_mem[12'h3A5] = 8'h5A;
    mem[12'h001] = 8'h96; exp_mem[12'h001] = 8'h96;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_sbusy", 32'(sbusy), 32'd0);
    chk("reset_svalid", 32'(svalid), 32'd0);
    chk("reset_wen_ren", 32'({mem_wen, mem_ren}), 32'd0);
    chk("reset_addr_wdata", 32'({mem_addr, mem_wdata}), 32'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Read 0x3A5 returning 0x5A.
    run_frame(1'b0, 12'h3A5, 8'h00, 0, 1'b0, -1, t0);
    @(posedge clk); #1;
    chk("rd_ren_T12", 32'(a_ren[t0+12]), 32'd1);
    chk("rd_ren_T11", 32'(a_ren[t0+11]), 32'd0);
    chk("rd_addr_T12", 32'(a_addr[t0+12]), 32'h3A5);
    chk("rd_svalid_T13", 32'(a_sv[t0+13]), 32'd0);
    chk("rd_svalid_T14", 32'(a_sv[t0+14]), 32'd1);
    chk("rd_svalid_T21", 32'(a_sv[t0+21]), 32'd1);
    chk("rd_svalid_T22", 32'(a_sv[t0+22]), 32'd0);
    for (int i = 0; i < D; i++) b[i] = a_sd[t0+14+i];
    chk("rd_byte", 32'(b), 32'h5A);
    chk("rd_sbusy_T22", 32'(a_busy[t0+22]), 32'd0);

    // Write 0x3A5 <- 0xC3.
    run_frame(1'b1, 12'h3A5, 8'hC3, 0, 1'b0, -1, t0);
    @(posedge clk); #1;
    chk("wr_wen_T20", 32'(a_wen[t0+20]), 32'd1);
    chk("wr_wen_T19", 32'(a_wen[t0+19]), 32'd0);
    chk("wr_wen_T21", 32'(a_wen[t0+21]), 32'd0);
    chk("wr_addr_T20", 32'(a_addr[t0+20]), 32'h3A5);
    chk("wr_wdata_T20", 32'(a_wdata[t0+20]), 32'hC3);
`ifdef SLAVE_PORT_WRITE_ACK_EN
    chk("wr_ack_T21", 32'({a_sv[t0+21], a_sd[t0+21]}), 32'd3);
    chk("wr_ack_T22", 32'(a_sv[t0+22]), 32'd0);
`else
    chk("wr_noack_T21", 32'(a_sv[t0+21]), 32'd0);
`endif

    // Abort after 5 address bits, then a read of 0x001 right away.
    run_frame(1'b1, 12'h2F0, 8'h11, 5, 1'b0, -1, t0);
    run_frame(1'b0, 12'h001, 8'h00, 0, 1'b0, -1, t1);
    @(posedge clk); #1;
    cnt = 0;
    for (int c = t0; c <= t0 + 6; c++) cnt += int'(a_wen[c]) + int'(a_ren[c]) + int'(a_sv[c]);
    chk("abort_no_strobe", 32'(cnt), 32'd0);
    chk("abort_sbusy_T6", 32'(a_busy[t0+6]), 32'd0);
    for (int i = 0; i < D; i++) b[i] = a_sd[t1+14+i];
    chk("abort_then_read", 32'(b), 32'h96);

    // Back-to-back write then read of 0xFFF.
    run_frame(1'b1, 12'hFFF, 8'hFF, 0, 1'b0, -1, t0);
    run_frame(1'b0, 12'hFFF, 8'h00, 0, 1'b0, -1, t1);
    @(posedge clk); #1;
    for (int i = 0; i < D; i++) b[i] = a_sd[t1+14+i];
    chk("b2b_read", 32'(b), 32'hFF);

    // Stray bus activity during the read's memory/serial phase.
    run_frame(1'b0, 12'h3A5, 8'h00, 0, 1'b1, -1, t0);
    @(posedge clk); #1;
    for (int i = 0; i < D; i++) b[i] = a_sd[t0+14+i];
    chk("stray_read", 32'(b), 32'hC3);

    // Reset pulse in the middle of RDATA, then recovery.
    run_frame(1'b0, 12'hFFF, 8'h00, 0, 1'b0, 5, t0);
    repeat (5) @(posedge clk);
    #1;
    cnt = 0;
    for (int c = t0 + A + 6; c <= t0 + A + 14; c++) cnt += int'(a_sv[c]);
    chk("rst_no_svalid", 32'(cnt), 32'd0);
    run_frame(1'b0, 12'h001, 8'h00, 0, 1'b0, -1, t0);

    // One more write/read pair.
    run_frame(1'b1, 12'h5C7, 8'h3E, 0, 1'b0, -1, t0);
    run_frame(1'b0, 12'h5C7, 8'h00, 0, 1'b0, -1, t1);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) b[i] = a_sd[t1+14+i];
    chk("final_read", 32'(b), 32'h3E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_port.md
# slave_port

Serial-to-parallel slave-side bus port. It receives address, mode and write data serially from the system bus (`swdata`/`smode`/`mvalid`) and issues single-cycle write or read strobes to the slave's local memory. For reads, it returns the data serially on `srdata`/`svalid`. It sits between the bus (master port via arbiter mux) and the slave memory inside a slave device.

## Interface
- `ADDR_WIDTH`, 12: local memory address width; number of serial address bits per frame.
- `DATA_WIDTH`, 8: data width; number of serial data bits per frame.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rstn` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `swdata` in 1: serial address/write data from bus, LSB first.
- `smode` in 1: 0 = read, 1 = write; sampled only on the first frame cycle.
- `mvalid` in 1: frame valid from master; high for every address/write-data bit.
- `srdata` out 1: serial read data to bus, LSB first.
- `svalid` out 1: `srdata` valid.
- `sbusy` out 1: high whenever FSM is not IDLE.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_wen` out 1: one-cycle write strobe.
- `mem_ren` out 1: one-cycle read strobe.
- `mem_rdata` in DATA_WIDTH: memory read data, valid exactly one cycle after `mem_ren`.

## Operation
- FSM states: IDLE, ADDR, WDATA, MEMWR, MEMRD, RWAIT, RDATA (plus ACK when configured).
- **IDLE:**
  - With `mvalid`=1: latch `smode`, shift in `swdata` as addr[0], set bit counter = 1, go to ADDR.
  - With `mvalid`=0: stay in IDLE.
- **ADDR:**
  - With `mvalid`=1: shift `swdata` into addr[counter].
  - After addr[ADDR_WIDTH-1] is captured: go to WDATA (write) or MEMRD (read), and clear the counter.
- **WDATA:** shift DATA_WIDTH bits LSB first; after the last bit, go to MEMWR.
- **MEMWR:** `mem_wen`=1 for one cycle with `mem_addr`/`mem_wdata` = latched values; go to IDLE.
- **MEMRD:** `mem_ren`=1 for one cycle; go to RWAIT.
- **RWAIT:** capture `mem_rdata` into the shift register; go to RDATA.
- **RDATA:** `svalid`=1 and `srdata` = shift[0], shifting right each cycle for DATA_WIDTH cycles; then go to IDLE.
- **Abort:** `mvalid`=0 while in ADDR or WDATA returns the FSM to IDLE.
  - No memory strobe is issued.
  - `svalid` is not asserted.
  - The partial frame is discarded.
- `mvalid`, `smode` and `swdata` are ignored in MEMWR, MEMRD, RWAIT, RDATA and ACK.
- `mem_addr`/`mem_wdata` hold their last latched values between transactions.
- Counter width is `$clog2(max(ADDR_WIDTH, DATA_WIDTH))+1`; the counter never wraps within a frame.

## Timing
- Frame start T0 is the first IDLE cycle with `mvalid`=1; A = ADDR_WIDTH, D = DATA_WIDTH.
- **Write:**
  - Address bits arrive T0..T(A-1); data bits arrive TA..T(A+D-1).
  - `mem_wen` is high during T(A+D).
  - The FSM is in IDLE at T(A+D+1), and a new frame may start in that cycle.
- **Read:**
  - `mem_ren` is high during TA.
  - `mem_rdata` is captured at the end of T(A+1).
  - `svalid` is high during T(A+2)..T(A+D+1).
  - The FSM is in IDLE at T(A+D+2).
- All outputs are registered.
- Reset values:
  - `srdata`, `svalid`, `sbusy`, `mem_wen`, `mem_ren` = 0.
  - `mem_addr`, `mem_wdata` = 0.
  - FSM = IDLE; counter and shift registers = 0.
- Reset asserted mid-transaction clears everything immediately. No strobe or `svalid` is emitted after `rstn` rises until a new frame is received.

## Configuration
- **`SLAVE_PORT_WRITE_ACK_EN` defined:** after MEMWR, the FSM enters ACK for one cycle (T(A+D+1)).
  - ACK drives `svalid`=1 and `srdata`=1.
  - The FSM is in IDLE at T(A+D+2).
- **Undefined:** ACK state is absent, and `svalid` is never asserted for writes.
- Reads are identical in both builds.

## Test plan
- **Write:** addr 0x3A5, data 0xC3, `smode`=1, contiguous `mvalid` for 20 cycles from T0 -> `mem_wen`=1 only at T20 with `mem_addr`=0x3A5 and `mem_wdata`=0xC3. With the macro, `svalid`/`srdata`=1 at T21 only.
- **Read:** addr 0x3A5, `smode`=0, memory model returns 0x5A -> `mem_ren` at T12; `svalid` high T14..T21 with `srdata` = 0,1,0,1,1,0,1,0; `sbusy` low at T22.
- **Abort:** `mvalid` drops after 5 address bits of a write -> no `mem_wen`/`mem_ren`, `sbusy` low the next cycle; a following read of 0x001 completes normally.
- **Back-to-back:** write 0xFFF/0xFF, then a read of 0xFFF starting in the first IDLE cycle -> both strobes are correct, and the read returns 0xFF serially.
- **Reset mid-read:** `rstn` pulsed low during RDATA -> `svalid`/`srdata`/`sbusy` go to 0 asynchronously, and no further `svalid` appears after release.
- **Stray inputs:** `mvalid` toggling during RWAIT/RDATA -> ignored; the serial read data is unchanged.
